// File: rtl/sprite_anim_sequencer_if.sv
// Signal bundle between the game-logic/VGA front end, the sprite ROM bank
// and the sprite animation sequencer.
interface sprite_anim_sequencer_if;
  logic        frame_start;
  logic [1:0]  dir;
  logic        moving;
  logic [9:0]  draw_x;
  logic [9:0]  draw_y;
  logic [9:0]  sprite_x;
  logic [9:0]  sprite_y;
  logic [9:0]  rom_addr;
  logic [31:0] rom_q;
  logic [3:0]  pixel_index;
  logic        pixel_valid;
  logic        anim_frame;

  modport master (
    output frame_start, dir, moving, draw_x, draw_y, sprite_x, sprite_y, rom_q,
    input  rom_addr, pixel_index, pixel_valid, anim_frame
  );

  modport slave (
    input  frame_start, dir, moving, draw_x, draw_y, sprite_x, sprite_y, rom_q,
    output rom_addr, pixel_index, pixel_valid, anim_frame
  );
endinterface

// File: rtl/sprite_anim_sequencer.sv
// Walk-cycle state machine plus a 3-stage address/select/pixel pipeline
// feeding the 8-ROM player sprite bank.
module sprite_anim_sequencer #(
  parameter int          SPRITE_W        = 32,
  parameter int          SPRITE_H        = 32,
  parameter int          FRAMES_PER_STEP = 8,
  parameter logic [3:0]  TRANSPARENT     = 4'd0
) (
  input  logic                   clk,
  input  logic                   rst,
  sprite_anim_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    STAND  = 2'd0,
    WALK_A = 2'd1,
    WALK_B = 2'd2
  } state_t;

  localparam logic [7:0] STEP_LAST = 8'(FRAMES_PER_STEP - 1);

  state_t      state_r;
  logic [1:0]  cur_dir_r;
  logic [7:0]  step_cnt_r;
  logic        anim_frame_r;

  logic [10:0] dx_s;
  logic [10:0] dy_s;
  logic [21:0] addr_wide_s;
  logic        hit_s;
  logic [9:0]  addr_s;

  logic [9:0]  rom_addr_r;
  logic [2:0]  sel_1_r;
  logic        hit_1_r;
  logic [2:0]  sel_2_r;
  logic        hit_2_r;
  logic [3:0]  pixel_index_r;
  logic        pixel_valid_r;
  logic [3:0]  rom_word_s;

  function automatic logic [3:0] select_nibble(input logic [31:0] q, input logic [2:0] sel);
    return q[{sel, 2'b00} +: 4];
  endfunction

  // Walk-cycle FSM; only advances on a frame_start pulse so sel never changes mid-frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= STAND;
      cur_dir_r    <= 2'd0;
      step_cnt_r   <= 8'd0;
      anim_frame_r <= 1'b0;
    end else if (bus.frame_start) begin
      cur_dir_r <= bus.dir;
      if (!bus.moving) begin
        state_r      <= STAND;
        step_cnt_r   <= 8'd0;
        anim_frame_r <= 1'b0;
      end else begin
        case (state_r)
          STAND: begin
            state_r      <= WALK_A;
            step_cnt_r   <= 8'd0;
            anim_frame_r <= 1'b0;
          end
          WALK_A, WALK_B: begin
            if (step_cnt_r == STEP_LAST) begin
              step_cnt_r   <= 8'd0;
              state_r      <= (state_r == WALK_A) ? WALK_B : WALK_A;
              anim_frame_r <= (state_r == WALK_A);
            end else begin
              step_cnt_r   <= step_cnt_r + 8'd1;
            end
          end
          default: begin
            state_r      <= STAND;
            step_cnt_r   <= 8'd0;
            anim_frame_r <= 1'b0;
          end
        endcase
      end
    end
  end

  // 11-bit differences: a negative offset shows up as a huge dx/dy and is also gated by the >= tests
  always_comb begin
    dx_s        = {1'b0, bus.draw_x} - {1'b0, bus.sprite_x};
    dy_s        = {1'b0, bus.draw_y} - {1'b0, bus.sprite_y};
    hit_s       = (bus.draw_x >= bus.sprite_x) && (bus.draw_y >= bus.sprite_y) &&
                  (dx_s < 11'(SPRITE_W)) && (dy_s < 11'(SPRITE_H));
    addr_wide_s = 22'(dy_s) * 22'(SPRITE_W) + 22'(dx_s);
    if (hit_s) begin
      addr_s = addr_wide_s[9:0];
    end else begin
      addr_s = 10'd0;
    end
    rom_word_s  = select_nibble(bus.rom_q, sel_2_r);
  end

  // Stage 1 address/select, stage 2 alignment with ROM read, stage 3 pixel output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_addr_r    <= 10'd0;
      sel_1_r       <= 3'd0;
      hit_1_r       <= 1'b0;
      sel_2_r       <= 3'd0;
      hit_2_r       <= 1'b0;
      pixel_index_r <= 4'd0;
      pixel_valid_r <= 1'b0;
    end else begin
      rom_addr_r    <= addr_s;
      sel_1_r       <= {cur_dir_r, anim_frame_r};
      hit_1_r       <= hit_s;
      sel_2_r       <= sel_1_r;
      hit_2_r       <= hit_1_r;
      pixel_index_r <= hit_2_r ? rom_word_s : 4'd0;
      pixel_valid_r <= hit_2_r && (rom_word_s != TRANSPARENT);
    end
  end

  assign bus.rom_addr    = rom_addr_r;
  assign bus.pixel_index = pixel_index_r;
  assign bus.pixel_valid = pixel_valid_r;
  assign bus.anim_frame  = anim_frame_r;

endmodule

// File: tb/tb_sprite_anim_sequencer.sv
// Directed bench: ROM bank model word(k,a) = (a + 3k + 5) mod 16, table of
// hit/address vectors, then walk-cycle and asynchronous reset sequences.
module tb_sprite_anim_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  sprite_anim_sequencer_if bus ();

  sprite_anim_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_bank(input logic [9:0] a);
    logic [31:0] q;
    q = 32'd0;
    for (int k = 0; k < 8; k++) begin
      q[4*k +: 4] = 4'((32'(a) + 32'(3 * k) + 32'd5) % 32'd16);
    end
    return q;
  endfunction

  // ROM bank: registered read of the shared address
  always @(posedge clk) bus.rom_q <= rom_bank(bus.rom_addr);

  typedef struct {
    logic [9:0] dx, dy, sx, sy;
    logic [9:0] addr;
    logic [3:0] idx;
    logic       valid;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    @(negedge clk);
    bus.draw_x = v.dx; bus.draw_y = v.dy; bus.sprite_x = v.sx; bus.sprite_y = v.sy;
    @(posedge clk); @(negedge clk);
    chk({tag, " rom_addr"}, 32'(bus.rom_addr), 32'(v.addr));
    @(posedge clk); @(posedge clk); @(negedge clk);
    chk({tag, " pixel_index"}, 32'(bus.pixel_index), 32'(v.idx));
    chk({tag, " pixel_valid"}, 32'(bus.pixel_valid), 32'(v.valid));
  endtask

  task automatic probe(input logic [3:0] idx, input string tag);
    vec_t v;
    v = '{10'd100, 10'd100, 10'd100, 10'd100, 10'd0, idx, 1'b1};
    run_vec(v, tag);
  endtask

  task automatic pulse(input logic [1:0] d, input logic mv);
    @(negedge clk);
    bus.dir = d; bus.moving = mv; bus.frame_start = 1'b1;
    @(negedge clk);
    bus.frame_start = 1'b0;
  endtask

  initial begin
    bus.frame_start = 1'b0; bus.dir = 2'd0; bus.moving = 1'b0;
    bus.draw_x = 10'd0; bus.draw_y = 10'd0; bus.sprite_x = 10'd0; bus.sprite_y = 10'd0;

    vecs[0]  = '{10'd100,  10'd100,  10'd100,  10'd100,  10'd0,    4'd5,  1'b1};
    vecs[1]  = '{10'd131,  10'd131,  10'd100,  10'd100,  10'd1023, 4'd4,  1'b1};
    vecs[2]  = '{10'd132,  10'd100,  10'd100,  10'd100,  10'd0,    4'd0,  1'b0};
    vecs[3]  = '{10'd99,   10'd100,  10'd100,  10'd100,  10'd0,    4'd0,  1'b0};
    vecs[4]  = '{10'd111,  10'd100,  10'd100,  10'd100,  10'd11,   4'd0,  1'b0};
    vecs[5]  = '{10'd1023, 10'd100,  10'd1000, 10'd100,  10'd23,   4'd12, 1'b1};
    vecs[6]  = '{10'd0,    10'd100,  10'd1000, 10'd100,  10'd0,    4'd0,  1'b0};
    vecs[7]  = '{10'd105,  10'd102,  10'd100,  10'd100,  10'd69,   4'd10, 1'b1};
    vecs[8]  = '{10'd100,  10'd132,  10'd100,  10'd100,  10'd0,    4'd0,  1'b0};
    vecs[9]  = '{10'd100,  10'd99,   10'd100,  10'd100,  10'd0,    4'd0,  1'b0};
    vecs[10] = '{10'd1023, 10'd1023, 10'd1000, 10'd1000, 10'd759,  4'd12, 1'b1};

    repeat (3) @(negedge clk);
    chk("reset rom_addr", 32'(bus.rom_addr), 32'd0);
    chk("reset pixel_index", 32'(bus.pixel_index), 32'd0);
    chk("reset pixel_valid", 32'(bus.pixel_valid), 32'd0);
    chk("reset anim_frame", 32'(bus.anim_frame), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // walk right: STAND -> WALK_A, 8 pulses -> WALK_B, 8 more -> WALK_A
    pulse(2'd3, 1'b1);
    chk("walk_a anim_frame", 32'(bus.anim_frame), 32'd0);
    probe(4'd7, "walk_a sel6");
    for (int i = 0; i < 7; i++) pulse(2'd3, 1'b1);
    chk("walk_a after 7 anim_frame", 32'(bus.anim_frame), 32'd0);
    pulse(2'd3, 1'b1);
    chk("walk_b anim_frame", 32'(bus.anim_frame), 32'd1);
    probe(4'd10, "walk_b sel7");
    for (int i = 0; i < 8; i++) pulse(2'd3, 1'b1);
    chk("walk_a again anim_frame", 32'(bus.anim_frame), 32'd0);
    probe(4'd7, "walk_a again sel6");

    // back to WALK_B, then stop facing up
    for (int i = 0; i < 8; i++) pulse(2'd3, 1'b1);
    chk("walk_b again anim_frame", 32'(bus.anim_frame), 32'd1);
    pulse(2'd1, 1'b0);
    chk("stand anim_frame", 32'(bus.anim_frame), 32'd0);
    probe(4'd11, "stand sel2");
    @(negedge clk); bus.dir = 2'd0; bus.moving = 1'b1;
    probe(4'd11, "dir change no pulse sel2");

    // restart walking; counter must have restarted at 0 from STAND
    pulse(2'd3, 1'b1);
    for (int i = 0; i < 7; i++) pulse(2'd3, 1'b1);
    chk("restart counter anim_frame", 32'(bus.anim_frame), 32'd0);
    pulse(2'd3, 1'b1);
    chk("pre-reset anim_frame", 32'(bus.anim_frame), 32'd1);

    // asynchronous reset mid-pipeline while walking
    @(negedge clk);
    bus.draw_x = 10'd100; bus.draw_y = 10'd100; bus.sprite_x = 10'd100; bus.sprite_y = 10'd100;
    repeat (3) @(posedge clk);
    chk("pre-reset pixel_valid", 32'(bus.pixel_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async rst rom_addr", 32'(bus.rom_addr), 32'd0);
    chk("async rst pixel_index", 32'(bus.pixel_index), 32'd0);
    chk("async rst pixel_valid", 32'(bus.pixel_valid), 32'd0);
    chk("async rst anim_frame", 32'(bus.anim_frame), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    chk("refill +2 pixel_valid", 32'(bus.pixel_valid), 32'd0);
    @(posedge clk); @(negedge clk);
    chk("refill +3 pixel_valid", 32'(bus.pixel_valid), 32'd1);
    chk("refill +3 pixel_index", 32'(bus.pixel_index), 32'd5);
    chk("post-reset anim_frame", 32'(bus.anim_frame), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sprite_anim_sequencer.md
# sprite_anim_sequencer

Animation and fetch controller for the 32x32 player-sprite ROM bank: eight 1024-entry palette-index ROMs, one per direction x walk frame, all with a 1-cycle registered read. The block latches direction and movement state at frame boundaries and steps a walk-cycle state machine. It also generates the shared ROM address from the current pixel and sprite position, then selects and pipelines the correct ROM output to the pixel compositor with a transparency-qualified valid flag. It sits between the game-logic/VGA timing front end and the color mapper.

## Interface
- SPRITE_W, 32, sprite width in pixels (power of two)
- SPRITE_H, 32, sprite height in pixels
- FRAMES_PER_STEP, 8, video frames per walk-frame toggle (1..255)
- TRANSPARENT, 0, palette index treated as see-through

- clock  in  1  system clock; all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- frame_start  in  1  one-cycle pulse at start of vertical blank
- dir  in  2  requested direction: 0 down, 1 up, 2 left, 3 right
- moving  in  1  player is walking
- draw_x, draw_y  in  10 each  current pixel coordinate
- sprite_x, sprite_y  in  10 each  sprite top-left coordinate
- rom_addr  out  10  shared address to all eight ROMs (registered)
- rom_q  in  32  packed ROM outputs, ROM k at bits [4k+3:4k], k = {dir,frame}
- pixel_index  out  4  selected palette index (registered)
- pixel_valid  out  1  pixel inside sprite and not TRANSPARENT (registered)
- anim_frame  out  1  current walk frame, for debug/LEDs

## Operation
- States: STAND, WALK_A, WALK_B. Reset -> STAND.
- Transitions are evaluated only on cycles with frame_start=1. Otherwise, state, latched dir (cur_dir), and step counter hold.
- On frame_start: cur_dir <= dir, sampled in the same cycle as moving.
- If moving=0 -> STAND, step counter <= 0.
- If moving=1 from STAND -> WALK_A, counter <= 0.
- If moving=1 in WALK_A/WALK_B: counter increments. When counter reaches FRAMES_PER_STEP-1, counter <= 0 and state toggles WALK_A<->WALK_B.
- anim_frame = 1 only in WALK_B. STAND and WALK_A use frame 0.
- Hit test uses 11-bit unsigned math: dx = draw_x - sprite_x, dy = draw_y - sprite_y. hit when draw_x >= sprite_x, draw_y >= sprite_y, dx < SPRITE_W, and dy < SPRITE_H. A sprite partially past 1023 wraps nothing; it simply never hits beyond 1023.
- Address = dy*SPRITE_W + dx (low 10 bits). When hit=0, rom_addr is 0.
- Select sel = {cur_dir, anim_frame} is registered alongside rom_addr and delayed one more cycle to align with rom_q.
- pixel_index = rom_q[sel_d]. pixel_valid = hit_d and (rom_q[sel_d] != TRANSPARENT). When hit_d=0, pixel_index is 0.

## Timing
- Stage 1 (edge N+1, inputs sampled at edge N): rom_addr, sel_1, and hit_1 registered.
- Stage 2 (edge N+2): ROM q valid; sel_2 and hit_2 registered.
- Stage 3 (edge N+3): pixel_index and pixel_valid registered. Total latency is 3 clocks from draw_x/draw_y.
- The front end compensates by presenting coordinates 3 clocks early.
- A direction or state change at frame_start takes effect on sel for pixels sampled from the next cycle onward. It never changes mid-frame.
- Reset values: rom_addr=0, pixel_index=0, pixel_valid=0, anim_frame=0, state STAND, cur_dir=0 (down), counter=0, all pipeline stages cleared.
- Reset mid-line: outputs go to 0 immediately (asynchronous). The pipeline refills 3 clocks after reset release.
- frame_start held high for multiple cycles is treated as one evaluation per cycle. The front end guarantees single-cycle pulses.

## Test plan
- After reset, with no frame_start: sprite at (100,100), draw (100,100) -> rom_addr=0 at +1, sel=0. With ROM 0 word 0 = 5: pixel_index=5, pixel_valid=1 at +3.
- Draw (131,131) with sprite (100,100) -> rom_addr=31*32+31=1023, hit=1. Draw (132,100) and draw (99,100) -> pixel_valid=0, rom_addr=0.
- dir=3, moving=1, pulse frame_start -> WALK_A, sel=6. After 8 more pulses -> WALK_B, anim_frame=1, sel=7. After 8 more -> WALK_A.
- In WALK_B, pulse frame_start with moving=0, dir=1 -> STAND, sel=2, counter=0. Changing dir between pulses leaves sel unchanged.
- ROM word holds TRANSPARENT (0) inside the sprite -> pixel_index=0, pixel_valid=0. Sprite at x=1000, draw_x=1023 -> hit; draw_x=0 -> no hit.
- Assert reset during walking and mid-pipeline -> all outputs 0 within the same cycle. After release, state is STAND and the first valid pixel appears 3 clocks later.
